// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants, bus widths, FSM encoding and address helper for the fetch stage
package if_fetch_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic RstEnable = 1'b1;
  localparam logic [InstAddrBus-1:0] ZeroWord = '0;
  localparam logic [InstBus-1:0] NopInst = '0;
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;
  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry pc+inst buffer; load captures new_pc/new_inst, unload empties, full/pc/inst expose contents
module fetch_skid_buf
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   unload,
  input  logic [InstAddrBus-1:0] new_pc,
  input  logic [InstBus-1:0]     new_inst,
  output logic                   full,
  output logic [InstAddrBus-1:0] pc,
  output logic [InstBus-1:0]     inst
);
  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) begin
      full <= 1'b0;
      pc   <= ZeroWord;
      inst <= NopInst;
    end else if (load) begin
      full <= 1'b1;
      pc   <= new_pc;
      inst <= new_inst;
    end else if (unload) begin
      full <= 1'b0;
    end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC owner issuing req/ack word fetches, delivering pc_o/inst_o/inst_valid_o to IF/ID, honouring branch redirects with one delay slot, raising stallreq_o while a fetch is unacked
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_address_i,
  output logic                   ibus_req_o,
  output logic [InstAddrBus-1:0] ibus_addr_o,
  input  logic                   ibus_ack_i,
  input  logic [InstBus-1:0]     ibus_rdata_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o,
  output logic                   stallreq_o
);
  fetch_state_e state, state_nx;
  logic [InstAddrBus-1:0] fetch_pc, redirect_target, next_pc, flag_target, buf_pc;
  logic [InstBus-1:0] buf_inst;
  logic redirect_pend, buf_full, ack, flag, take, park, bubble, release_buf;
  assign ack         = (state == S_FETCH) & ibus_ack_i;
  assign flag        = branch_flag_i & ~stall_i;
  assign flag_target = word_align(branch_target_address_i);
  assign take        = ack & ~stall_i;
  assign park        = ack & stall_i;
  assign bubble      = (state == S_FETCH) & ~ibus_ack_i & ~stall_i;
  assign release_buf = (state == S_HOLD) & buf_full & ~stall_i;
  assign next_pc     = flag ? flag_target : redirect_pend ? redirect_target : fetch_pc + 32'd4;
  fetch_skid_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (park),
    .unload  (release_buf),
    .new_pc  (fetch_pc),
    .new_inst(ibus_rdata_i),
    .full    (buf_full),
    .pc      (buf_pc),
    .inst    (buf_inst)
  );
  always_comb begin
    state_nx    = state;
    ibus_req_o  = 1'b0;
    ibus_addr_o = ZeroWord;
    stallreq_o  = 1'b0;
    case (state)
      S_RESET: state_nx = S_FETCH;
      S_FETCH: begin
        ibus_req_o  = 1'b1;
        ibus_addr_o = word_align(fetch_pc);
        stallreq_o  = ~ibus_ack_i;
        state_nx    = park ? S_HOLD : S_FETCH;
      end
      S_HOLD:  state_nx = (~stall_i | ~buf_full) ? S_FETCH : S_HOLD;
      default: state_nx = S_RESET;
    endcase
  end
  // A flag seen in S_HOLD belongs to the buffered delay slot, so the target
  // becomes the very next fetch address; in S_FETCH without an ack it is parked
  // until the outstanding delay-slot fetch completes.
  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) begin
      state           <= S_RESET;
      fetch_pc        <= RESET_PC;
      redirect_pend   <= 1'b0;
      redirect_target <= ZeroWord;
      pc_o            <= ZeroWord;
      inst_o          <= NopInst;
      inst_valid_o    <= 1'b0;
    end else begin
      state <= state_nx;
      if (ack) fetch_pc <= next_pc;
      else if (flag & (state == S_HOLD)) fetch_pc <= flag_target;
      if (ack) redirect_pend <= 1'b0;
      else if (flag & (state == S_FETCH)) begin
        redirect_pend   <= 1'b1;
        redirect_target <= flag_target;
      end
      if (take) begin
        pc_o         <= fetch_pc;
        inst_o       <= ibus_rdata_i;
        inst_valid_o <= 1'b1;
      end else if (release_buf) begin
        pc_o         <= buf_pc;
        inst_o       <= buf_inst;
        inst_valid_o <= 1'b1;
      end else if (bubble) begin
        inst_o       <= NopInst;
        inst_valid_o <= 1'b0;
      end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized scoreboard bench; model predicts the fetch address stream from delay-slot rules
module tb_if_fetch;
  logic clk = 1'b0, rst = 1'b1, stall_i = 1'b0, branch_flag_i = 1'b0, ibus_ack_i = 1'b0;
  logic [31:0] branch_target_address_i = '0, ibus_rdata_i = '0;
  logic ibus_req_o, inst_valid_o, stallreq_o;
  logic [31:0] ibus_addr_o, pc_o, inst_o;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } item_t;
  item_t sb[$];
  item_t it;
  int compared = 0, mismatched = 0, consumed = 0;
  logic [31:0] exp_addr, prev_pc;
  logic have_prev, parked;
  int wait_left;
  always #5 clk = ~clk;
  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i), .ibus_req_o(ibus_req_o),
    .ibus_addr_o(ibus_addr_o), .ibus_ack_i(ibus_ack_i), .ibus_rdata_i(ibus_rdata_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o), .stallreq_o(stallreq_o)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] x;
    x = (a >> 2) * 32'h9e37_79b1;
    x = x ^ (x >> 13);
    return (x[20:18] == 3'd0) ? {6'h04, 10'h0, x[15:0]} : {6'h08, x[25:0]};
  endfunction
  function automatic logic is_branch(input logic [31:0] i);
    return i[31:26] == 6'h04;
  endfunction
  function automatic logic [31:0] tgt(input logic [31:0] i);
    return {16'h0, i[15:0]};
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  task automatic model_reset();
    sb.delete();
    exp_addr = 32'h0;
    prev_pc = 32'h0;
    have_prev = 1'b0;
    parked = 1'b0;
    wait_left = -1;
  endtask
  task automatic drive_cycle();
    logic [31:0] nxt;
    stall_i = ($urandom_range(0, 99) < 30);
    branch_flag_i = inst_valid_o && is_branch(inst_o);
    branch_target_address_i = branch_flag_i ? tgt(inst_o) : $urandom;
    ibus_ack_i = 1'b0;
    ibus_rdata_i = $urandom;
    if (parked) check("req_in_hold", {31'h0, ibus_req_o}, 32'h0);
    parked = 1'b0;
    if (ibus_req_o) begin
      check("fetch_addr", ibus_addr_o, exp_addr);
      if (wait_left < 0) wait_left = $urandom_range(0, 3);
      if (wait_left == 0) begin
        ibus_ack_i = 1'b1;
        ibus_rdata_i = mem(ibus_addr_o);
        sb.push_back({exp_addr, mem(exp_addr)});
        nxt = (have_prev && is_branch(mem(prev_pc))) ? (tgt(mem(prev_pc)) & ~32'h3) : exp_addr + 32'd4;
        prev_pc = exp_addr;
        have_prev = 1'b1;
        exp_addr = nxt;
        wait_left = -1;
        parked = stall_i;
      end else wait_left--;
    end
  endtask
  task automatic check_zero_outputs(input string tag);
    check({tag, "_pc"}, pc_o, 32'h0);
    check({tag, "_inst"}, inst_o, 32'h0);
    check({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h0);
    check({tag, "_req"}, {31'h0, ibus_req_o}, 32'h0);
    check({tag, "_addr"}, ibus_addr_o, 32'h0);
    check({tag, "_stallreq"}, {31'h0, stallreq_o}, 32'h0);
  endtask
  task automatic release_reset();
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    ibus_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    model_reset();
    rst = 1'b0;
    ibus_ack_i = 1'b1;
    ibus_rdata_i = 32'hdead_beef;
    #1;
    check("req_after_release", {31'h0, ibus_req_o}, 32'h0);
    @(posedge clk);
    #1;
    ibus_ack_i = 1'b0;
    check("first_req", {31'h0, ibus_req_o}, 32'h1);
    check("stray_ack_valid", {31'h0, inst_valid_o}, 32'h0);
  endtask
  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive_cycle();
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      check("stallreq", {31'h0, stallreq_o}, {31'h0, ibus_req_o & ~ibus_ack_i});
      check("addr_align", {30'h0, ibus_addr_o[1:0]}, 32'h0);
      if (!inst_valid_o) check("bubble_inst", inst_o, 32'h0);
      if (inst_valid_o && !stall_i) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL deliver: unexpected pc %h inst %h, nothing expected", pc_o, inst_o);
        end else begin
          it = sb.pop_front();
          check("deliver_pc", pc_o, it.pc);
          check("deliver_inst", inst_o, it.inst);
          consumed++;
        end
      end
    end
  initial begin
    bit found;
    model_reset();
    release_reset();
    run(1500);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      drive_cycle();
      if (ibus_req_o && !ibus_ack_i) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("midwait_found", {31'h0, found}, 32'h1);
    rst = 1'b1;
    #1;
    check_zero_outputs("midreset");
    release_reset();
    run(1500);
    stall_i = 1'b0;
    ibus_ack_i = 1'b0;
    check("enough_delivered", {31'h0, consumed > 300}, 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
